xphy_link_monitor: RTL and testbench



---
 rtl/l2sw_pkg.sv | 8 +
 rtl/xphy_link_monitor_if.sv | 18 +
 rtl/xphy_link_port.sv | 118 +++++++++++
 rtl/xphy_link_monitor.sv | 37 +++
 tb/tb_xphy_link_monitor.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/l2sw_pkg.sv
// l2sw_pkg: shared link/blink state types and XGMII start-lane constants
package l2sw_pkg;
  typedef enum logic [1:0] {DOWN, UP_WAIT, UP, DOWN_WAIT} link_st_t;
  typedef enum logic [1:0] {IDLE, OFF, ON} blink_st_t;
  localparam logic [7:0] XGMII_START = 8'hFB;
  localparam int START_LANE0 = 0;
  localparam int START_LANE1 = 4;
endpackage

// File: rtl/xphy_link_monitor_if.sv
// xphy_link_monitor_if: per-port PHY status/XGMII RX inputs and link supervisor outputs
interface xphy_link_monitor_if #(
  parameter int NPORTS = 4,
  parameter int CNT_W  = 16
);
  logic [8*NPORTS-1:0]     xphy_status;
  logic [64*NPORTS-1:0]    xgmii_rxd;
  logic [8*NPORTS-1:0]     xgmii_rxc;
  logic                    flap_clr;
  logic [NPORTS-1:0]       link_up;
  logic [NPORTS-1:0]       link_chg;
  logic [CNT_W*NPORTS-1:0] flap_cnt;
  logic [NPORTS-1:0]       led;
  modport master (output xphy_status, xgmii_rxd, xgmii_rxc, flap_clr,
                  input  link_up, link_chg, flap_cnt, led);
  modport slave  (input  xphy_status, xgmii_rxd, xgmii_rxc, flap_clr,
                  output link_up, link_chg, flap_cnt, led);
endinterface

// File: rtl/xphy_link_port.sv
// xphy_link_port: one port's block-lock debounce FSM, flap counter and LED (blink with XPHY_LINK_ACTIVITY_BLINK_EN)
module xphy_link_port
  import l2sw_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 156250,
  parameter int BLINK_CYC    = 7812500,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_stat,
  input  logic [63:0]      i_rxd,
  input  logic [7:0]       i_rxc,
  input  logic             i_flap_clr,
  output logic             o_link_up,
  output logic             o_link_chg,
  output logic [CNT_W-1:0] o_flap_cnt,
  output logic             o_led
);
  localparam int DW = $clog2(DEBOUNCE_CYC);
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYC - 1);
  logic             r_stat;
  logic [63:0]      r_rxd;
  logic [7:0]       r_rxc;
  link_st_t         r_state, w_state_nx;
  logic [DW-1:0]    r_dcnt, w_dcnt_nx;
  logic             r_link_up, r_link_chg, w_up_nx, w_flap, w_act;
  logic [CNT_W-1:0] r_flap_cnt;
  always_comb begin
    w_state_nx = r_state;
    w_dcnt_nx  = r_dcnt;
    case (r_state)
      DOWN: if (r_stat) begin
        w_state_nx = UP_WAIT;
        w_dcnt_nx  = '0;
      end
      UP_WAIT:
        if (!r_stat) w_state_nx = DOWN;
        else if (r_dcnt == D_LAST) w_state_nx = UP;
        else w_dcnt_nx = r_dcnt + 1'b1;
      UP: if (!r_stat) begin
        w_state_nx = DOWN_WAIT;
        w_dcnt_nx  = '0;
      end
      default:
        if (r_stat) w_state_nx = UP;
        else if (r_dcnt == D_LAST) w_state_nx = DOWN;
        else w_dcnt_nx = r_dcnt + 1'b1;
    endcase
  end
  // link_up registers the next state so it lands on the same edge the FSM enters UP/DOWN
  assign w_up_nx = (w_state_nx == UP) || (w_state_nx == DOWN_WAIT);
  assign w_flap  = (r_state == DOWN_WAIT) && (w_state_nx == DOWN);
  assign w_act   = r_link_up &
                   ((r_rxc[START_LANE0] & (r_rxd[8*START_LANE0 +: 8] == XGMII_START)) |
                    (r_rxc[START_LANE1] & (r_rxd[8*START_LANE1 +: 8] == XGMII_START)));
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat     <= 1'b0;
      r_rxd      <= '0;
      r_rxc      <= '0;
      r_state    <= DOWN;
      r_dcnt     <= '0;
      r_link_up  <= 1'b0;
      r_link_chg <= 1'b0;
      r_flap_cnt <= '0;
    end else begin
      r_stat     <= i_stat;
      r_rxd      <= i_rxd;
      r_rxc      <= i_rxc;
      r_state    <= w_state_nx;
      r_dcnt     <= w_dcnt_nx;
      r_link_up  <= w_up_nx;
      r_link_chg <= w_up_nx ^ r_link_up;
      r_flap_cnt <= i_flap_clr ? '0 : (w_flap && !(&r_flap_cnt)) ? r_flap_cnt + 1'b1 : r_flap_cnt;
    end
  end
  assign o_link_up  = r_link_up;
  assign o_link_chg = r_link_chg;
  assign o_flap_cnt = r_flap_cnt;
`ifdef XPHY_LINK_ACTIVITY_BLINK_EN
  localparam int BW = $clog2(BLINK_CYC + 1);
  localparam logic [BW-1:0] B_LAST = BW'(BLINK_CYC - 1);
  blink_st_t     r_bst, w_bst_nx;
  logic [BW-1:0] r_bcnt, w_bcnt_nx;
  always_comb begin
    w_bst_nx  = r_bst;
    w_bcnt_nx = r_bcnt;
    if (!r_link_up) w_bst_nx = IDLE;
    else case (r_bst)
      IDLE: if (w_act) begin
        w_bst_nx  = OFF;
        w_bcnt_nx = '0;
      end
      OFF:
        if (r_bcnt == B_LAST) begin
          w_bst_nx  = ON;
          w_bcnt_nx = '0;
        end else w_bcnt_nx = r_bcnt + 1'b1;
      default:
        if (r_bcnt == B_LAST) w_bst_nx = IDLE;
        else w_bcnt_nx = r_bcnt + 1'b1;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bst  <= IDLE;
      r_bcnt <= '0;
    end else begin
      r_bst  <= w_bst_nx;
      r_bcnt <= w_bcnt_nx;
    end
  end
  assign o_led = r_link_up & (r_bst != OFF);
`else
  assign o_led = r_link_up;
`endif
endmodule

// File: rtl/xphy_link_monitor.sv
// xphy_link_monitor: NPORTS-wide link supervisor; slices the flattened buses onto xphy_link_port instances
// Optional RX-activity LED blink is enabled by defining XPHY_LINK_ACTIVITY_BLINK_EN.
module xphy_link_monitor #(
  parameter int NPORTS       = 4,
  parameter int DEBOUNCE_CYC = 156250,
  parameter int BLINK_CYC    = 7812500,
  parameter int CNT_W        = 16
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  xphy_link_monitor_if.slave  bus
);
  logic [NPORTS-1:0]       w_link_up, w_link_chg, w_led;
  logic [CNT_W*NPORTS-1:0] w_flap_cnt;
  for (genvar g = 0; g < NPORTS; g++) begin : g_port
    xphy_link_port #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC),
      .BLINK_CYC   (BLINK_CYC),
      .CNT_W       (CNT_W)
    ) u_port (
      .clk       (sys_clk),
      .rst       (sys_rst),
      .i_stat    (bus.xphy_status[8*g]),
      .i_rxd     (bus.xgmii_rxd[64*g +: 64]),
      .i_rxc     (bus.xgmii_rxc[8*g +: 8]),
      .i_flap_clr(bus.flap_clr),
      .o_link_up (w_link_up[g]),
      .o_link_chg(w_link_chg[g]),
      .o_flap_cnt(w_flap_cnt[CNT_W*g +: CNT_W]),
      .o_led     (w_led[g])
    );
  end
  assign bus.link_up  = w_link_up;
  assign bus.link_chg = w_link_chg;
  assign bus.flap_cnt = w_flap_cnt;
  assign bus.led      = w_led;
endmodule

// File: tb/tb_xphy_link_monitor.sv
// tb_xphy_link_monitor: directed checks of debounce, flap counting, clear priority, LED and reset
module tb_xphy_link_monitor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;
  xphy_link_monitor_if #(.NPORTS(2), .CNT_W(4)) bus ();
  xphy_link_monitor #(.NPORTS(2), .DEBOUNCE_CYC(4), .BLINK_CYC(3), .CNT_W(4)) dut (
    .sys_clk(clk),
    .sys_rst(rst),
    .bus    (bus)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic go_up();
    bus.xphy_status[0] = 1'b1;
    repeat (6) tick();
  endtask
  task automatic go_down();
    bus.xphy_status[0] = 1'b0;
    repeat (6) tick();
  endtask
  task automatic test_reset();
    rst = 1'b1;
    bus.xphy_status = '0;
    bus.xgmii_rxd = '0;
    bus.xgmii_rxc = '0;
    bus.flap_clr = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    checks++;
    if ({bus.link_up, bus.link_chg, bus.led, bus.flap_cnt} !== 14'h0) begin
      errors++;
      $display("FAIL reset_state: got up=%b chg=%b led=%b flap=%h, want all 0",
               bus.link_up, bus.link_chg, bus.led, bus.flap_cnt);
    end
  endtask
  task automatic test_rise();
    bus.xphy_status[0] = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      tick();
      checks++;
      if (bus.link_up !== 2'b00) begin
        errors++;
        $display("FAIL rise_early edge %0d: got %b want 00", e, bus.link_up);
      end
    end
    tick();
    checks++;
    if (bus.link_up !== 2'b01 || bus.link_chg !== 2'b01 || bus.led !== 2'b01) begin
      errors++;
      $display("FAIL rise_edge6: got up=%b chg=%b led=%b want 01/01/01", bus.link_up, bus.link_chg, bus.led);
    end
    tick();
    checks++;
    if (bus.link_chg !== 2'b00 || bus.link_up !== 2'b01) begin
      errors++;
      $display("FAIL rise_pulse_end: got chg=%b up=%b want 00/01", bus.link_chg, bus.link_up);
    end
  endtask
  task automatic test_glitch();
    logic bad = 1'b0;
    bus.xphy_status[0] = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (i == 3) bus.xphy_status[0] = 1'b1;
      tick();
      if (bus.link_up !== 2'b01 || bus.link_chg !== 2'b00) bad = 1'b1;
    end
    checks++;
    if (bad || bus.flap_cnt[3:0] !== 4'h0) begin
      errors++;
      $display("FAIL glitch: link dropped=%b flap=%h want 0/0", bad, bus.flap_cnt[3:0]);
    end
  endtask
  task automatic test_flap();
    bus.xphy_status[0] = 1'b0;
    repeat (5) tick();
    checks++;
    if (bus.link_up[0] !== 1'b1) begin
      errors++;
      $display("FAIL fall_early: got %b want 1", bus.link_up[0]);
    end
    tick();
    checks++;
    if (bus.link_up[0] !== 1'b0 || bus.link_chg[0] !== 1'b1 || bus.flap_cnt[3:0] !== 4'h1) begin
      errors++;
      $display("FAIL fall_edge6: got up=%b chg=%b flap=%h want 0/1/1",
               bus.link_up[0], bus.link_chg[0], bus.flap_cnt[3:0]);
    end
    for (int i = 2; i <= 16; i++) begin
      go_up();
      go_down();
      if (i == 15) begin
        checks++;
        if (bus.flap_cnt[3:0] !== 4'hF) begin
          errors++;
          $display("FAIL flap_15: got %h want f", bus.flap_cnt[3:0]);
        end
      end
    end
    checks++;
    if (bus.flap_cnt[3:0] !== 4'hF || bus.flap_cnt[7:4] !== 4'h0) begin
      errors++;
      $display("FAIL flap_sat: got %h want 0f", bus.flap_cnt);
    end
  endtask
  task automatic test_clear_coincide();
    bus.flap_clr = 1'b1;
    tick();
    bus.flap_clr = 1'b0;
    checks++;
    if (bus.flap_cnt[3:0] !== 4'h0) begin
      errors++;
      $display("FAIL clear: got %h want 0", bus.flap_cnt[3:0]);
    end
    repeat (5) begin
      go_up();
      go_down();
    end
    checks++;
    if (bus.flap_cnt[3:0] !== 4'h5) begin
      errors++;
      $display("FAIL flap_5: got %h want 5", bus.flap_cnt[3:0]);
    end
    go_up();
    bus.xphy_status[0] = 1'b0;
    repeat (5) tick();
    bus.flap_clr = 1'b1;
    tick();
    bus.flap_clr = 1'b0;
    checks++;
    if (bus.flap_cnt[3:0] !== 4'h0 || bus.link_up[0] !== 1'b0) begin
      errors++;
      $display("FAIL clear_wins: got flap=%h up=%b want 0/0", bus.flap_cnt[3:0], bus.link_up[0]);
    end
  endtask
  task automatic test_activity();
    logic exp_led;
    go_up();
    bus.xgmii_rxc[7:0] = 8'h01;
    bus.xgmii_rxd[7:0] = 8'hFB;
    tick();
    bus.xgmii_rxc[7:0] = 8'h00;
    bus.xgmii_rxd[7:0] = 8'h00;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 1) begin
        bus.xgmii_rxc[7:0] = 8'h01;
        bus.xgmii_rxd[7:0] = 8'hFB;
      end
      if (i == 2) begin
        bus.xgmii_rxc[7:0] = 8'h00;
        bus.xgmii_rxd[7:0] = 8'h00;
      end
`ifdef XPHY_LINK_ACTIVITY_BLINK_EN
      exp_led = (i >= 4);
`else
      exp_led = 1'b1;
`endif
      checks++;
      if (bus.led[0] !== exp_led) begin
        errors++;
        $display("FAIL blink cycle %0d: got %b want %b", i, bus.led[0], exp_led);
      end
    end
  endtask
  task automatic test_reset_mid();
    logic exp_led;
    go_down();
    go_up();
    bus.xphy_status[8] = 1'b1;
    bus.xgmii_rxc[7:0] = 8'h10;
    bus.xgmii_rxd[39:32] = 8'hFB;
    tick();
    bus.xgmii_rxc[7:0] = 8'h00;
    bus.xgmii_rxd[39:32] = 8'h00;
    tick();
`ifdef XPHY_LINK_ACTIVITY_BLINK_EN
    exp_led = 1'b0;
`else
    exp_led = 1'b1;
`endif
    checks++;
    if (bus.led[0] !== exp_led || bus.flap_cnt[3:0] !== 4'h1) begin
      errors++;
      $display("FAIL lane4_blink: got led=%b flap=%h want %b/1", bus.led[0], bus.flap_cnt[3:0], exp_led);
    end
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if ({bus.link_up, bus.link_chg, bus.led, bus.flap_cnt} !== 14'h0) begin
      errors++;
      $display("FAIL reset_mid: got up=%b chg=%b led=%b flap=%h want all 0",
               bus.link_up, bus.link_chg, bus.led, bus.flap_cnt);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (bus.link_chg !== 2'b00 || bus.link_up !== 2'b00) begin
      errors++;
      $display("FAIL reset_release: got chg=%b up=%b want 00/00", bus.link_chg, bus.link_up);
    end
    repeat (5) tick();
    checks++;
    if (bus.link_up !== 2'b11 || bus.link_chg !== 2'b11) begin
      errors++;
      $display("FAIL relink: got up=%b chg=%b want 11/11", bus.link_up, bus.link_chg);
    end
  endtask
  initial begin
    test_reset();
    test_rise();
    test_glitch();
    test_flap();
    test_clear_coincide();
    test_activity();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
